// File: rtl/ip_spi_master.sv
// SPI mode-0 master: one word per chip-select frame, MSB first, registered outputs.
// Define SPIMASTER_BURST_EN to let a word accepted in the last HOLD cycle continue the frame.
`timescale 1ns/1ps
module ip_spi_master #(
  parameter int WORD_W   = 16,
  parameter int HALF_DIV = 4,
  parameter int CS_SETUP = 2,
  parameter int CS_GAP   = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WORD_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic [WORD_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              busy,
  output logic              sck,
  output logic              mosi,
  input  logic              miso,
  output logic              ncs,
  output logic [2:0]        state_dbg
);

  // Handshake: a word moves when tx_valid && tx_ready at a rising clk edge;
  // the source holds tx_valid/tx_data stable until then.
  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;

  localparam int MAX_AB  = (HALF_DIV > CS_SETUP) ? HALF_DIV : CS_SETUP;
  localparam int CNT_MAX = (MAX_AB > CS_GAP) ? MAX_AB : CS_GAP;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int BIT_W   = (WORD_W > 1) ? $clog2(WORD_W) : 1;

  localparam logic [CNT_W-1:0] HALF_LAST  = CNT_W'(HALF_DIV - 1);
  localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(CS_SETUP - 1);
  localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(CS_GAP - 1);
  localparam logic [BIT_W-1:0] BIT_LAST   = BIT_W'(WORD_W - 1);
`ifdef SPIMASTER_BURST_EN
  localparam logic [CNT_W-1:0] HOLD_OPEN  = CNT_W'(HALF_DIV - 2);
`endif

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [BIT_W-1:0]  bit_cnt;
  logic [WORD_W-1:0] tx_sr;
  logic [WORD_W-1:0] rx_sr;

  assign state_dbg = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      bit_cnt  <= '0;
      tx_sr    <= '0;
      rx_sr    <= '0;
      rx_data  <= '0;
      rx_valid <= 1'b0;
      tx_ready <= 1'b0;
      busy     <= 1'b0;
      sck      <= 1'b0;
      mosi     <= 1'b0;
      ncs      <= 1'b1;
    end else begin
      rx_valid <= 1'b0;
      case (state)
        IDLE: begin
          tx_ready <= 1'b1;
          busy     <= 1'b0;
          ncs      <= 1'b1;
          sck      <= 1'b0;
          if (tx_valid && tx_ready) begin
            tx_sr    <= tx_data;
            mosi     <= tx_data[WORD_W-1];
            tx_ready <= 1'b0;
            busy     <= 1'b1;
            ncs      <= 1'b0;
            cnt      <= '0;
            state    <= SETUP;
          end
        end

        SETUP: begin
          if (cnt == SETUP_LAST) begin
            cnt     <= '0;
            bit_cnt <= '0;
            state   <= SHIFT;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        // Each half-period ends on cnt == HALF_LAST; rising half samples miso,
        // falling half advances mosi unless it was the last bit.
        SHIFT: begin
          if (cnt == HALF_LAST) begin
            cnt <= '0;
            if (!sck) begin
              sck   <= 1'b1;
              rx_sr <= {rx_sr[WORD_W-2:0], miso};
            end else begin
              sck <= 1'b0;
              if (bit_cnt == BIT_LAST) begin
                state <= HOLD;
              end else begin
                bit_cnt <= bit_cnt + 1'b1;
                tx_sr   <= tx_sr << 1;
                mosi    <= tx_sr[WORD_W-2];
              end
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        HOLD: begin
`ifdef SPIMASTER_BURST_EN
          if (cnt == HOLD_OPEN) tx_ready <= 1'b1;
`endif
          if (cnt == HALF_LAST) begin
            cnt      <= '0;
            rx_data  <= rx_sr;
            rx_valid <= 1'b1;
`ifdef SPIMASTER_BURST_EN
            if (tx_valid && tx_ready) begin
              tx_sr    <= tx_data;
              mosi     <= tx_data[WORD_W-1];
              tx_ready <= 1'b0;
              bit_cnt  <= '0;
              state    <= SHIFT;
            end else begin
              tx_ready <= 1'b0;
              ncs      <= 1'b1;
              mosi     <= 1'b0;
              state    <= GAP;
            end
`else
            ncs   <= 1'b1;
            mosi  <= 1'b0;
            state <= GAP;
`endif
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        GAP: begin
          if (cnt == GAP_LAST) begin
            cnt      <= '0;
            tx_ready <= 1'b1;
            busy     <= 1'b0;
            state    <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ip_spi_master.sv
// Bench for ip_spi_master: 16-bit master against a mode-0 slave model, plus an
// 8-bit, HALF_DIV=2 instance with miso looped back to mosi.
`timescale 1ns/1ps
module tb_ip_spi_master;
  localparam int W = 16;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // 16-bit instance
  logic [W-1:0] tx_data = '0;
  logic         tx_valid = 1'b0;
  logic         tx_ready, rx_valid, busy, sck, mosi, miso, ncs;
  logic [W-1:0] rx_data;
  logic [2:0]   state_dbg;

  ip_spi_master dut (
    .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .busy(busy), .sck(sck), .mosi(mosi),
    .miso(miso), .ncs(ncs), .state_dbg(state_dbg)
  );

  // 8-bit loopback instance
  logic [7:0] tx_data8 = '0;
  logic       tx_valid8 = 1'b0;
  logic       tx_ready8, rx_valid8, busy8, sck8, mosi8, ncs8;
  logic [7:0] rx_data8;
  logic [2:0] state_dbg8;

  ip_spi_master #(.WORD_W(8), .HALF_DIV(2)) dut8 (
    .clk(clk), .rst(rst), .tx_data(tx_data8), .tx_valid(tx_valid8), .tx_ready(tx_ready8),
    .rx_data(rx_data8), .rx_valid(rx_valid8), .busy(busy8), .sck(sck8), .mosi(mosi8),
    .miso(mosi8), .ncs(ncs8), .state_dbg(state_dbg8)
  );

  // mode-0 slave: reply latched at ncs fall, mosi captured on sck rise
  logic [W-1:0] slave_word = '0;
  logic [W-1:0] slave_latch = '0;
  logic [W-1:0] slave_rx = '0;
  logic [7:0]   rise_cnt = '0;
  always @(negedge ncs) slave_latch = slave_word;
  always @(posedge sck or posedge ncs) begin
    if (ncs) rise_cnt = '0;
    else begin
      rise_cnt = rise_cnt + 8'd1;
      slave_rx = {slave_rx[W-2:0], mosi};
    end
  end
  assign miso = slave_latch[4'd15 - rise_cnt[3:0]];

  // scoreboard and observation queues
  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_mosi_q[$];
  logic [W-1:0] obs_rx_q[$];
  logic [W-1:0] obs_mosi_q[$];
  int acc_cyc_q[$];
  int obs_cyc_q[$];

  int vectors = 0;
  int miscompares = 0;

  logic [W-1:0] drv_words[4];
  logic [W-1:0] drv_replies[4];
  int   ncs_falls, min_gap, ncs_low, sck_rises, mosi_bad;
  logic drv_timeout;

  // driver: sends n words from drv_words, records what the DUT produces
  task automatic run_words(input int n);
    int idx = 0, got = 0, n_cyc = 0, tail = 0, gap_run = 0;
    logic pending = 1'b0, seen_frame = 1'b0;
    logic prev_ncs, prev_sck, prev_mosi;
    ncs_falls = 0; min_gap = 1000; ncs_low = 0; sck_rises = 0; mosi_bad = 0;
    drv_timeout = 1'b0;
    obs_rx_q.delete(); obs_mosi_q.delete(); obs_cyc_q.delete(); acc_cyc_q.delete();
    @(negedge clk);
    prev_ncs = ncs; prev_sck = sck; prev_mosi = mosi;
    slave_word = drv_replies[0]; tx_data = drv_words[0]; tx_valid = 1'b1;
    while (tail < 6) begin
      if (tx_valid && tx_ready) begin
        pending = 1'b1;
        acc_cyc_q.push_back(cyc);
        exp_q.push_back(drv_replies[idx]);
        exp_mosi_q.push_back(tx_data);
      end
      @(negedge clk);
      n_cyc++;
      if (pending) begin
        pending = 1'b0;
        idx++;
        if (idx < n) begin
          tx_data = drv_words[idx];
          slave_word = drv_replies[idx];
        end else begin
          tx_valid = 1'b0;
        end
      end
      if (rx_valid) begin
        got++;
        obs_rx_q.push_back(rx_data);
        obs_mosi_q.push_back(slave_rx);
        obs_cyc_q.push_back(cyc);
      end
      if (!ncs) ncs_low++;
      if (!ncs && prev_ncs) begin
        ncs_falls++;
        if (seen_frame && gap_run < min_gap) min_gap = gap_run;
        seen_frame = 1'b1;
      end
      gap_run = ncs ? gap_run + 1 : 0;
      if (sck && !prev_sck) sck_rises++;
      if ((mosi !== prev_mosi) && sck) mosi_bad++;
      prev_ncs = ncs; prev_sck = sck; prev_mosi = mosi;
      if (got >= n) tail++;
      if (n_cyc > 2000) begin
        drv_timeout = 1'b1;
        break;
      end
    end
    tx_valid = 1'b0;
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    tx_valid = 1'b1; tx_data = 16'hFFFF;
    @(negedge clk);
    vectors++; if (ncs !== 1'b1) begin miscompares++; $display("FAIL rst_ncs: got %b expected 1", ncs); end
    vectors++; if (sck !== 1'b0) begin miscompares++; $display("FAIL rst_sck: got %b expected 0", sck); end
    vectors++; if (mosi !== 1'b0) begin miscompares++; $display("FAIL rst_mosi: got %b expected 0", mosi); end
    vectors++; if (rx_data !== 16'h0000) begin miscompares++; $display("FAIL rst_rx_data: got %h expected 0000", rx_data); end
    vectors++; if (rx_valid !== 1'b0) begin miscompares++; $display("FAIL rst_rx_valid: got %b expected 0", rx_valid); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rst_busy: got %b expected 0", busy); end
    vectors++; if (tx_ready !== 1'b0) begin miscompares++; $display("FAIL rst_tx_ready: got %b expected 0", tx_ready); end
    vectors++; if (state_dbg !== 3'd0) begin miscompares++; $display("FAIL rst_state: got %0d expected 0", state_dbg); end
    rst = 1'b0; tx_valid = 1'b0;
    @(negedge clk);
    vectors++; if (tx_ready !== 1'b1) begin miscompares++; $display("FAIL rst_release_ready: got %b expected 1", tx_ready); end
    vectors++; if (tx_ready8 !== 1'b1) begin miscompares++; $display("FAIL rst_release_ready8: got %b expected 1", tx_ready8); end
    // reset and a valid word in the same cycle while ready: reset must win
    rst = 1'b1; tx_valid = 1'b1;
    @(negedge clk);
    vectors++; if (busy !== 1'b0 || ncs !== 1'b1) begin
      miscompares++; $display("FAIL rst_vs_valid: got busy=%b ncs=%b expected busy=0 ncs=1", busy, ncs);
    end
    rst = 1'b0; tx_valid = 1'b0;
    @(negedge clk);
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rst_vs_valid_after: got busy=%b expected 0", busy); end
  endtask

  task automatic test_single;
    logic [W-1:0] e, o;
    drv_words[0] = 16'hA55A; drv_replies[0] = 16'h1234;
    run_words(1);
    vectors++; if (drv_timeout !== 1'b0) begin miscompares++; $display("FAIL single_timeout: got %b expected 0", drv_timeout); end
    vectors++; if (obs_rx_q.size() != 1) begin miscompares++; $display("FAIL single_rx_count: got %0d expected 1", obs_rx_q.size()); end
    while (exp_q.size() > 0 && obs_rx_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_rx_q.pop_front();
      vectors++; if (o !== e) begin miscompares++; $display("FAIL single_rx_data: got %h expected %h", o, e); end
      e = exp_mosi_q.pop_front(); o = obs_mosi_q.pop_front();
      vectors++; if (o !== e) begin miscompares++; $display("FAIL single_mosi: got %h expected %h", o, e); end
      vectors++; if (obs_cyc_q[0] - acc_cyc_q[0] != 135) begin
        miscompares++; $display("FAIL single_latency: got %0d expected 135", obs_cyc_q[0] - acc_cyc_q[0]);
      end
    end
    vectors++; if (ncs_low != 134) begin miscompares++; $display("FAIL single_ncs_low: got %0d expected 134", ncs_low); end
    vectors++; if (sck_rises != 16) begin miscompares++; $display("FAIL single_sck_rises: got %0d expected 16", sck_rises); end
    vectors++; if (mosi_bad != 0) begin miscompares++; $display("FAIL single_mosi_while_sck_high: got %0d expected 0", mosi_bad); end
    vectors++; if (rx_data !== 16'h1234 || rx_valid !== 1'b0) begin
      miscompares++; $display("FAIL single_rx_hold: got %h/%b expected 1234/0", rx_data, rx_valid);
    end
    exp_q.delete(); exp_mosi_q.delete();
  endtask

  task automatic test_back_to_back;
    logic [W-1:0] e, o;
    drv_words[0] = 16'h0001; drv_replies[0] = 16'hBEEF;
    drv_words[1] = 16'h8000; drv_replies[1] = 16'h0F0F;
    run_words(2);
    vectors++; if (drv_timeout !== 1'b0) begin miscompares++; $display("FAIL b2b_timeout: got %b expected 0", drv_timeout); end
    vectors++; if (obs_rx_q.size() != 2) begin miscompares++; $display("FAIL b2b_rx_count: got %0d expected 2", obs_rx_q.size()); end
    vectors++; if (ncs_falls != 2) begin miscompares++; $display("FAIL b2b_frames: got %0d expected 2", ncs_falls); end
    vectors++; if (min_gap < 2) begin miscompares++; $display("FAIL b2b_gap: got %0d expected >=2", min_gap); end
    vectors++; if (sck_rises != 32) begin miscompares++; $display("FAIL b2b_sck_rises: got %0d expected 32", sck_rises); end
    while (exp_q.size() > 0 && obs_rx_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_rx_q.pop_front();
      vectors++; if (o !== e) begin miscompares++; $display("FAIL b2b_rx_data: got %h expected %h", o, e); end
      e = exp_mosi_q.pop_front(); o = obs_mosi_q.pop_front();
      vectors++; if (o !== e) begin miscompares++; $display("FAIL b2b_mosi: got %h expected %h", o, e); end
    end
    exp_q.delete(); exp_mosi_q.delete();
  endtask

`ifdef SPIMASTER_BURST_EN
  task automatic test_burst;
    logic [W-1:0] e, o;
    drv_words[0] = 16'hFFFF; drv_words[1] = 16'h0000; drv_words[2] = 16'hC3C3;
    for (int i = 0; i < 3; i++) drv_replies[i] = 16'h6B6B;
    run_words(3);
    vectors++; if (drv_timeout !== 1'b0) begin miscompares++; $display("FAIL burst_timeout: got %b expected 0", drv_timeout); end
    vectors++; if (obs_rx_q.size() != 3) begin miscompares++; $display("FAIL burst_rx_count: got %0d expected 3", obs_rx_q.size()); end
    vectors++; if (ncs_falls != 1) begin miscompares++; $display("FAIL burst_frames: got %0d expected 1", ncs_falls); end
    vectors++; if (sck_rises != 48) begin miscompares++; $display("FAIL burst_sck_rises: got %0d expected 48", sck_rises); end
    if (obs_cyc_q.size() == 3) begin
      vectors++; if (obs_cyc_q[1] - obs_cyc_q[0] != 132 || obs_cyc_q[2] - obs_cyc_q[1] != 132) begin
        miscompares++; $display("FAIL burst_spacing: got %0d,%0d expected 132,132",
                                obs_cyc_q[1] - obs_cyc_q[0], obs_cyc_q[2] - obs_cyc_q[1]);
      end
    end
    while (exp_q.size() > 0 && obs_rx_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_rx_q.pop_front();
      vectors++; if (o !== e) begin miscompares++; $display("FAIL burst_rx_data: got %h expected %h", o, e); end
      e = exp_mosi_q.pop_front(); o = obs_mosi_q.pop_front();
      vectors++; if (o !== e) begin miscompares++; $display("FAIL burst_mosi: got %h expected %h", o, e); end
    end
    exp_q.delete(); exp_mosi_q.delete();
  endtask
`endif

  task automatic test_reset_mid_frame;
    logic [W-1:0] e, o;
    int n = 0, rises = 0, saw_rx = 0;
    logic prev_sck;
    @(negedge clk);
    slave_word = 16'h0F0F; tx_data = 16'h3333; tx_valid = 1'b1;
    prev_sck = sck;
    while (rises < 8 && n < 400) begin
      @(negedge clk); n++;
      if (busy && !tx_ready) tx_valid = 1'b0;
      if (sck && !prev_sck) rises++;
      if (rx_valid) saw_rx++;
      prev_sck = sck;
    end
    vectors++; if (rises != 8) begin miscompares++; $display("FAIL abort_reach_8th_rise: got %0d expected 8", rises); end
    rst = 1'b1;
    @(negedge clk);
    vectors++; if (ncs !== 1'b1 || sck !== 1'b0) begin
      miscompares++; $display("FAIL abort_lines: got ncs=%b sck=%b expected ncs=1 sck=0", ncs, sck);
    end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL abort_busy: got %b expected 0", busy); end
    rst = 1'b0;
    for (int i = 0; i < 150; i++) begin
      @(negedge clk);
      if (rx_valid) saw_rx++;
    end
    vectors++; if (saw_rx != 0) begin miscompares++; $display("FAIL abort_no_rx_valid: got %0d pulses expected 0", saw_rx); end
    drv_words[0] = 16'h5A5A; drv_replies[0] = 16'hA5C3;
    run_words(1);
    vectors++; if (obs_rx_q.size() != 1 || drv_timeout !== 1'b0) begin
      miscompares++; $display("FAIL abort_recover_count: got %0d expected 1", obs_rx_q.size());
    end
    while (exp_q.size() > 0 && obs_rx_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_rx_q.pop_front();
      vectors++; if (o !== e) begin miscompares++; $display("FAIL abort_recover_rx: got %h expected %h", o, e); end
      e = exp_mosi_q.pop_front(); o = obs_mosi_q.pop_front();
      vectors++; if (o !== e) begin miscompares++; $display("FAIL abort_recover_mosi: got %h expected %h", o, e); end
    end
    exp_q.delete(); exp_mosi_q.delete();
  endtask

  task automatic test_busy_protect;
    int n = 0, ready_hi = 0, pulses = 0;
    logic accepted = 1'b0;
    logic [W-1:0] got_rx = '0, got_mosi = '0;
    @(negedge clk);
    slave_word = 16'h0F0F; tx_data = 16'h3C3C; tx_valid = 1'b1;
    exp_q.push_back(16'h0F0F); exp_mosi_q.push_back(16'h3C3C);
    while (pulses == 0 && n < 400) begin
      if (!accepted && tx_valid && tx_ready) accepted = 1'b1;
      @(negedge clk); n++;
      if (rx_valid) begin pulses++; got_rx = rx_data; got_mosi = slave_rx; end
      if (accepted) begin
        if (state_dbg == 3'd2) begin
          if (tx_ready) ready_hi++;
          tx_data = 16'hDEAD; tx_valid = ~tx_valid;
        end else begin
          tx_valid = 1'b0;
        end
      end
    end
    tx_valid = 1'b0;
    vectors++; if (pulses != 1) begin miscompares++; $display("FAIL busy_rx_count: got %0d expected 1", pulses); end
    vectors++; if (ready_hi != 0) begin miscompares++; $display("FAIL busy_tx_ready: got %0d high cycles expected 0", ready_hi); end
    vectors++; if (got_mosi !== exp_mosi_q[0]) begin miscompares++; $display("FAIL busy_mosi: got %h expected %h", got_mosi, exp_mosi_q[0]); end
    vectors++; if (got_rx !== exp_q[0]) begin miscompares++; $display("FAIL busy_rx_data: got %h expected %h", got_rx, exp_q[0]); end
    exp_q.delete(); exp_mosi_q.delete();
    repeat (10) @(negedge clk);
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL busy_no_extra_frame: got busy=%b expected 0", busy); end
  endtask

  task automatic test_param_sweep;
    int n = 0, acc = 0, rx_at = -1, rise0 = -1, rise1 = -1, high_len = 0;
    logic prev_sck, drop = 1'b0, in_high = 1'b0;
    logic [W-1:0] e;
    @(negedge clk);
    tx_data8 = 8'h96; tx_valid8 = 1'b1;
    prev_sck = sck8;
    while (rx_at < 0 && n < 200) begin
      if (tx_valid8 && tx_ready8) begin
        acc = cyc; drop = 1'b1;
        exp_q.push_back({8'h00, tx_data8});
      end
      @(negedge clk); n++;
      if (drop) begin tx_valid8 = 1'b0; drop = 1'b0; end
      if (sck8 && !prev_sck) begin
        if (rise0 < 0) begin rise0 = cyc; in_high = 1'b1; end
        else if (rise1 < 0) rise1 = cyc;
      end
      if (in_high) begin
        if (sck8) high_len++;
        else in_high = 1'b0;
      end
      if (rx_valid8) rx_at = cyc;
      prev_sck = sck8;
    end
    vectors++; if (rx_at < 0) begin miscompares++; $display("FAIL sweep_timeout: got no rx_valid expected one"); end
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      vectors++; if ({8'h00, rx_data8} !== e) begin miscompares++; $display("FAIL sweep_rx_data: got %h expected %h", rx_data8, e[7:0]); end
    end
    vectors++; if (rise1 - rise0 != 4) begin miscompares++; $display("FAIL sweep_sck_period: got %0d expected 4", rise1 - rise0); end
    vectors++; if (high_len != 2) begin miscompares++; $display("FAIL sweep_sck_high: got %0d expected 2", high_len); end
    vectors++; if (rx_at - acc != 37) begin miscompares++; $display("FAIL sweep_latency: got %0d expected 37", rx_at - acc); end
    exp_q.delete();
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
`ifdef SPIMASTER_BURST_EN
    test_burst();
`endif
    test_reset_mid_frame();
    test_busy_protect();
    test_param_sweep();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
